// File: rtl/lane_traffic_engine_if.sv
//----------------------------------------------------------------------------
// lane_traffic_engine_if
// Bundles the movement controls, frog position and car/collision outputs of
// lane_traffic_engine. The master side is the game top level; the slave side
// is the engine. o_Car_Tail_X is present only when CAR_WIDE_EN is defined.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface lane_traffic_engine_if #(
  parameter int NUM_LANES  = 16,
  parameter int LANE_IDX_W = 4,
  parameter int COL_W      = 5,
  parameter int ROW_W      = 4
);
  logic                       i_Tick;
  logic                       i_Freeze;
  logic                       i_Restart;
  logic [3:0]                 i_Level;
  logic [COL_W-1:0]           i_Frog_Col;
  logic [ROW_W-1:0]           i_Frog_Row;
  logic [NUM_LANES*COL_W-1:0] o_Car_X;
  logic [NUM_LANES*ROW_W-1:0] o_Car_Y;
  logic [NUM_LANES-1:0]       o_Step;
  logic                       o_Collision;
  logic                       o_Collision_Pulse;
  logic [LANE_IDX_W-1:0]      o_Hit_Lane;
`ifdef CAR_WIDE_EN
  logic [NUM_LANES*COL_W-1:0] o_Car_Tail_X;
`endif

  modport master (
    output i_Tick, i_Freeze, i_Restart, i_Level, i_Frog_Col, i_Frog_Row,
    input  o_Car_X, o_Car_Y, o_Step, o_Collision, o_Collision_Pulse, o_Hit_Lane
`ifdef CAR_WIDE_EN
    , input o_Car_Tail_X
`endif
  );

  modport slave (
    input  i_Tick, i_Freeze, i_Restart, i_Level, i_Frog_Col, i_Frog_Row,
    output o_Car_X, o_Car_Y, o_Step, o_Collision, o_Collision_Pulse, o_Hit_Lane
`ifdef CAR_WIDE_EN
    , output o_Car_Tail_X
`endif
  );
endinterface

`default_nettype wire

// File: rtl/lane_traffic_engine.sv
//----------------------------------------------------------------------------
// lane_traffic_engine
// Moves one car per lane across a GRID_COLS-wide row, one column per period.
// The period shrinks with game level (floored at MIN_PERIOD) and fast lanes
// use half of it. Frog/car overlap is registered into a collision level, a
// rising-edge pulse and the lowest overlapping lane index.
// Optional macro CAR_WIDE_EN: two-column cars (head plus trailing column) and
// the extra o_Car_Tail_X output.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module lane_traffic_engine #(
  parameter int                         NUM_LANES   = 16,
  parameter int                         LANE_IDX_W  = 4,
  parameter int                         COL_W       = 5,
  parameter int                         ROW_W       = 4,
  parameter int                         GRID_COLS   = 20,
  parameter int                         CNT_W       = 24,
  parameter int                         BASE_PERIOD = 980,
  parameter int                         LEVEL_STEP  = 60,
  parameter int                         MIN_PERIOD  = 100,
  parameter logic [NUM_LANES*ROW_W-1:0] LANE_ROW    = '0,
  parameter logic [NUM_LANES*COL_W-1:0] LANE_START  = '0,
  parameter logic [NUM_LANES-1:0]       LANE_DIR    = '1,
  parameter logic [NUM_LANES-1:0]       LANE_FAST   = '0
) (
  input  wire logic             i_Clk,
  input  wire logic             i_Reset,
  lane_traffic_engine_if.slave  bus
);

  // Period arithmetic is widened by 4 bits so level*step cannot wrap silently.
  localparam int               c_pw          = CNT_W + 4;
  localparam logic [c_pw-1:0]  c_base_period = c_pw'(BASE_PERIOD);
  localparam logic [c_pw-1:0]  c_level_step  = c_pw'(LEVEL_STEP);
  localparam logic [c_pw-1:0]  c_min_period  = c_pw'(MIN_PERIOD);

  logic [c_pw-1:0]            w_level_prod;
  logic [c_pw-1:0]            w_period_diff;
  logic [CNT_W-1:0]           w_period_next;
  logic [CNT_W-1:0]           r_period;

  logic [COL_W-1:0]           w_pos [NUM_LANES];
  logic [NUM_LANES-1:0]       w_step;
  logic [NUM_LANES-1:0]       w_match;
  logic [NUM_LANES*COL_W-1:0] w_car_x;

  logic                       w_any_match;
  logic [LANE_IDX_W-1:0]      w_hit_next;
  logic                       r_collision;
  logic                       r_collision_pulse;
  logic [LANE_IDX_W-1:0]      r_hit_lane;

  // Level-scaled period with a floor; an underflowing subtraction also floors.
  always_comb begin
    w_level_prod  = c_pw'(bus.i_Level) * c_level_step;
    w_period_diff = c_base_period - w_level_prod;
    if ((w_level_prod > c_base_period) || (w_period_diff < c_min_period)) begin
      w_period_next = c_min_period[CNT_W-1:0];
    end else begin
      w_period_next = w_period_diff[CNT_W-1:0];
    end
  end

  // Period register follows the level one cycle later.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_period <= CNT_W'(BASE_PERIOD);
    end else begin
      r_period <= w_period_next;
    end
  end

`ifdef CAR_WIDE_EN
  logic [COL_W-1:0]           w_tail [NUM_LANES];
  logic [NUM_LANES*COL_W-1:0] w_car_tail_x;
`endif

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    localparam logic [COL_W-1:0] c_start = LANE_START[gi*COL_W +: COL_W];
    localparam logic [ROW_W-1:0] c_row   = LANE_ROW[gi*ROW_W +: ROW_W];
    localparam logic [COL_W-1:0] c_last  = COL_W'(GRID_COLS - 1);

    logic [CNT_W-1:0] w_lane_period;
    logic [COL_W-1:0] w_next_pos;
    logic [COL_W-1:0] r_pos;
    logic [CNT_W-1:0] r_cnt;
    logic             r_step;

    // Lane period: halved for fast lanes, never below 2 ticks.
    always_comb begin
      w_lane_period = LANE_FAST[gi] ? (r_period >> 1) : r_period;
      if (w_lane_period < CNT_W'(2)) begin
        w_lane_period = CNT_W'(2);
      end
    end

    // Next column in the lane's direction with wrap at the grid edges.
    always_comb begin
      if (LANE_DIR[gi]) begin
        w_next_pos = (r_pos == c_last) ? '0 : r_pos + COL_W'(1);
      end else begin
        w_next_pos = (r_pos == '0) ? c_last : r_pos - COL_W'(1);
      end
    end

    // Counter and position: restart beats freeze beats tick.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
        r_pos  <= c_start;
        r_cnt  <= '0;
        r_step <= 1'b0;
      end else if (bus.i_Restart) begin
        r_pos  <= c_start;
        r_cnt  <= '0;
        r_step <= 1'b0;
      end else if (bus.i_Freeze) begin
        r_step <= 1'b0;
      end else if (bus.i_Tick) begin
        // >= lets a shrunken period step right away instead of overrunning.
        if (r_cnt >= (w_lane_period - CNT_W'(1))) begin
          r_cnt  <= '0;
          r_pos  <= w_next_pos;
          r_step <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_step <= 1'b0;
        end
      end else begin
        r_step <= 1'b0;
      end
    end

    assign w_pos[gi]  = r_pos;
    assign w_step[gi] = r_step;

`ifdef CAR_WIDE_EN
    logic [COL_W-1:0] w_tail_col;

    // Trailing column sits behind the head, wrapping around the grid.
    always_comb begin
      if (LANE_DIR[gi]) begin
        w_tail_col = (r_pos == '0) ? c_last : r_pos - COL_W'(1);
      end else begin
        w_tail_col = (r_pos == c_last) ? '0 : r_pos + COL_W'(1);
      end
    end

    assign w_tail[gi]  = w_tail_col;
    assign w_match[gi] = (c_row == bus.i_Frog_Row) &&
                         ((r_pos == bus.i_Frog_Col) || (w_tail_col == bus.i_Frog_Col));
`else
    assign w_match[gi] = (c_row == bus.i_Frog_Row) && (r_pos == bus.i_Frog_Col);
`endif
  end

  // Pack per-lane head columns onto the output bus.
  always_comb begin
    w_car_x = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_car_x[i*COL_W +: COL_W] = w_pos[i];
    end
  end

`ifdef CAR_WIDE_EN
  // Pack per-lane trailing columns for the display.
  always_comb begin
    w_car_tail_x = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_car_tail_x[i*COL_W +: COL_W] = w_tail[i];
    end
  end

  assign bus.o_Car_Tail_X = w_car_tail_x;
`endif

  // Any overlap; scanning downwards leaves the lowest matching lane.
  always_comb begin
    w_any_match = 1'b0;
    w_hit_next  = r_hit_lane;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_any_match = 1'b1;
        w_hit_next  = LANE_IDX_W'(i);
      end
    end
  end

  // Collision level, its rising-edge pulse and the held hit lane.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_collision       <= 1'b0;
      r_collision_pulse <= 1'b0;
      r_hit_lane        <= '0;
    end else begin
      r_collision       <= w_any_match;
      r_collision_pulse <= w_any_match & ~r_collision;
      r_hit_lane        <= w_hit_next;
    end
  end

  assign bus.o_Car_X           = w_car_x;
  assign bus.o_Car_Y           = LANE_ROW;
  assign bus.o_Step            = w_step;
  assign bus.o_Collision       = r_collision;
  assign bus.o_Collision_Pulse = r_collision_pulse;
  assign bus.o_Hit_Lane        = r_hit_lane;

endmodule

`default_nettype wire
